crc_arbiter: RTL
================

// Module: crc_arbiter
// PURPOSE
// - Shares one bit-serial checksum engine (40-bit word in, 16-bit CRC out) between two requesters:
//   req 0 = UART TX framer (generate CRC), req 1 = UART RX deframer (check CRC).
// - Round-robin grant; drives engine data/we/mask; returns result + status to granted requester.
// - Sits between UART framing logic and the checksum instance; the engine is never touched directly.
// PARAMETERS
// - DATA_W   40          engine word width (3 payload bytes + 16-bit CRC field)
// - CRC_W    16          result width
// - POLY     17'h11021   polynomial mask driven on eng_mask_o (CRC-16-CCITT)
// - TMO_CYC  127         watchdog limit in cycles (only with CRC_TIMEOUT_EN)
// PORTS
// - clk_i         in   1        system clock, rising edge
// - rst_i         in   1        synchronous reset, active-high
// - req_i         in   2        per-requester request level; held until matching ack_o pulse
// - data0_i       in   DATA_W   requester 0 word; stable while req_i[0]=1
// - data1_i       in   DATA_W   requester 1 word; stable while req_i[1]=1
// - ack_o         out  2        one-cycle completion pulse to granted requester
// - res_o         out  CRC_W    result; valid in the ack_o cycle, held until next ack
// - ok_o          out  1        res_o==0 (RX check pass); valid with ack_o
// - tmo_o         out  1        1 = op aborted by watchdog; valid with ack_o
// - busy_o        out  1        1 in any state other than IDLE
// - eng_data_o    out  DATA_W   to engine data_i
// - eng_we_o      out  1        to engine we_i; one-cycle start pulse
// - eng_mask_o    out  CRC_W+1  to engine mask_i; constant POLY
// - eng_out_i     in   CRC_W    from engine out_o
// - eng_valid_i   in   1        from engine out_valid_o (level, may stay high between ops)
// BEHAVIOUR
// - Reset: state=IDLE, ack_o=0, res_o=0, ok_o=0, tmo_o=0, busy_o=0, eng_we_o=0,
//   eng_data_o=0, rr_ptr=0 (req 0 preferred first), armed=0. eng_mask_o=POLY always.
// - rst_i mid-operation: immediate return to reset state; no ack issued; engine result discarded.
// - FSM IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
//   IDLE: if any req_i, grant = rr_ptr side if requesting else the other; latch grant,
//     eng_data_o <= granted data; go LAUNCH. No requests -> stay.
//   LAUNCH: eng_we_o=1 for exactly this cycle; armed<=0; go WAIT.
//   WAIT: armed<=1 once eng_valid_i sampled 0; when armed && eng_valid_i: res_o<=eng_out_i,
//     ok_o<=(eng_out_i==0), tmo_o<=0; go DONE. Stale high valid before arming is ignored.
//   DONE: ack_o[grant]=1 one cycle; rr_ptr<=~grant; go IDLE.
// - Latency: request seen in IDLE at cycle N -> eng_we_o at N+1 -> ack at engine latency +3 min.
// - Simultaneous req_i=2'b11: rr_ptr side wins; loser served next; no starvation (strict alternation).
// - Requester must drop req in the cycle after ack_o; req still high in IDLE = new request, but
//   round-robin already favours the other side.
// - req_i dropped by requester mid-op: op completes, ack still pulsed (protocol violation, tolerated).
// - Grant, eng_data_o, ok_o, tmo_o change only at the state edges listed; no combinational paths
//   from req_i to eng_we_o.
// CONFIGURATION
// - CRC_TIMEOUT_EN defined: 7-bit counter cleared in LAUNCH, increments in WAIT; reaching TMO_CYC
//   -> res_o<=16'hFFFF, ok_o<=0, tmo_o<=1, go DONE (ack still issued, rr_ptr still toggles).
// - CRC_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; tmo_o tied 0.
// TESTING (bench uses engine stub: valid low on we, high 40 cycles later, out = data[15:0]^16'hA5A5)
// - rst_i=1 3 cycles, then idle -> all outputs 0, eng_mask_o=17'h11021, busy_o=0.
// - req_i=01, data0={"Hi!",16'h0000} -> one eng_we_o pulse, eng_data_o=data0, ack_o=01 with
//   res_o=16'hA5A5, ok_o=0, tmo_o=0.
// - req_i=10, data1={"Hi!",16'hA5A5} -> ack_o=10, res_o=16'h0000, ok_o=1.
// - req_i=11 held continuously 4 ops -> grants 0,1,0,1; exactly one ack per op, never both bits.
// - stub valid held high from previous op, new launch -> result taken only after valid low->high.
// - stub never asserts valid: with CRC_TIMEOUT_EN ack after 127 WAIT cycles, res_o=16'hFFFF,
//   tmo_o=1; without it busy_o stays 1; rst_i mid-WAIT -> IDLE next cycle, no ack.

Source files
------------

// File: rtl/crc_arbiter.sv
// Round-robin arbiter sharing one bit-serial CRC engine between a UART TX framer (req 0)
// and an RX deframer (req 1). Define CRC_TIMEOUT_EN to add a WAIT-state watchdog.
module crc_arbiter #(
    parameter int                DATA_W  = 40,
    parameter int                CRC_W   = 16,
    parameter logic [CRC_W:0]    POLY    = 17'h11021,
    parameter int                TMO_CYC = 127
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic [1:0]        ack_o,
    output logic [CRC_W-1:0]  res_o,
    output logic              ok_o,
    output logic              tmo_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] eng_data_o,
    output logic              eng_we_o,
    output logic [CRC_W:0]    eng_mask_o,
    input  logic [CRC_W-1:0]  eng_out_i,
    input  logic              eng_valid_i
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_q, rr_d;
    logic                armed_q, armed_d;
    logic [CRC_W-1:0]    res_q, res_d;
    logic                ok_q, ok_d;
    logic [DATA_W-1:0]   data_q, data_d;
`ifdef CRC_TIMEOUT_EN
    logic                tmo_q, tmo_d;
    logic [6:0]          cnt_q, cnt_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            armed_q <= 1'b0;
            res_q   <= '0;
            ok_q    <= 1'b0;
            data_q  <= '0;
`ifdef CRC_TIMEOUT_EN
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            armed_q <= armed_d;
            res_q   <= res_d;
            ok_q    <= ok_d;
            data_q  <= data_d;
`ifdef CRC_TIMEOUT_EN
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        armed_d = armed_q;
        res_d   = res_q;
        ok_d    = ok_q;
        data_d  = data_q;
`ifdef CRC_TIMEOUT_EN
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = req_i[rr_q] ? rr_q : ~rr_q;
                    data_d  = grant_d ? data1_i : data0_i;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                armed_d = 1'b0;
`ifdef CRC_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // A valid level left over from the previous op only counts after a low sample.
                if (!eng_valid_i)
                    armed_d = 1'b1;
                if (armed_q && eng_valid_i) begin
                    res_d   = eng_out_i;
                    ok_d    = (eng_out_i == '0);
`ifdef CRC_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                    state_d = DONE;
                end
`ifdef CRC_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == 7'(TMO_CYC - 1)) begin
                        res_d   = {CRC_W{1'b1}};
                        ok_d    = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end
            DONE: begin
                rr_d    = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack_o      = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign res_o      = res_q;
    assign ok_o       = ok_q;
`ifdef CRC_TIMEOUT_EN
    assign tmo_o      = tmo_q;
`else
    assign tmo_o      = 1'b0;
`endif
    assign busy_o     = (state_q != IDLE);
    assign eng_data_o = data_q;
    assign eng_we_o   = (state_q == LAUNCH);
    assign eng_mask_o = POLY;

endmodule
